game_mode_arbiter: RTL and testbench

Parametrised N-mode game-controller arbiter between the per-mode game engines (one-player, two-player, and later modes) and the shared renderer / I2C link. It selects one active engine from the mode switch, registers its ball state onto a single output bus, and gates `game_start` and enables to that engine only. Mode changes are deferred until the active engine is idle or game-over, then passed through a blanking interval. A live switch flip therefore never tears a rally.

---
 rtl/game_mode_arbiter.sv | 95 +++++++++
 tb/tb_game_mode_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/game_mode_arbiter.sv
// game_mode_arbiter: routes one of NUM_MODES game engines to the shared renderer, deferring mode switches until idle.
// Optional GAME_MODE_SYNC_EN: 2-flop synchroniser plus 2-cycle glitch filter on mode_sel.
module game_mode_arbiter #(
    parameter int NUM_MODES = 2,
    parameter int COORD_W = 10,
    parameter int BLANK_CYCLES = 2,
    parameter int DEFAULT_MODE = 0,
    localparam int SEL_W = NUM_MODES > 2 ? $clog2(NUM_MODES) : 1
) (
    input  logic                         clk_25MHZ,
    input  logic                         reset,
    input  logic [SEL_W-1:0]             mode_sel,
    input  logic                         game_start,
    input  logic [NUM_MODES*COORD_W-1:0] ch_ball_x,
    input  logic [NUM_MODES*COORD_W-1:0] ch_ball_y,
    input  logic [NUM_MODES-1:0]         ch_moving_left,
    input  logic [NUM_MODES-1:0]         ch_game_over,
    input  logic [NUM_MODES-1:0]         ch_idle,
    output logic [NUM_MODES-1:0]         ch_enable,
    output logic [NUM_MODES-1:0]         ch_game_start,
    output logic [COORD_W-1:0]           ball_x_out,
    output logic [COORD_W-1:0]           ball_y_out,
    output logic                         is_ball_moving_left,
    output logic                         game_over,
    output logic                         ball_valid,
    output logic [SEL_W-1:0]             active_mode,
    output logic                         switch_busy
);
    typedef enum logic [1:0] {RUN, DRAIN, BLANK} state_t;
    state_t state;
    logic [SEL_W-1:0] target, raw_sel, sel_q;
    logic [7:0] blank_cnt;
    logic [COORD_W-1:0] sel_x, sel_y;
`ifdef GAME_MODE_SYNC_EN
    logic [SEL_W-1:0] sync1, sync2, sync3;
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= mode_sel;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end
    // an unsettled request reads as "no change"
    assign raw_sel = (sync2 == sync3) ? sync2 : active_mode;
`else
    assign raw_sel = mode_sel;
`endif
    assign sel_q = (32'(raw_sel) < NUM_MODES) ? raw_sel : active_mode;
    assign sel_x = ch_ball_x[32'(active_mode)*COORD_W +: COORD_W];
    assign sel_y = ch_ball_y[32'(active_mode)*COORD_W +: COORD_W];
    assign ch_enable = (state == BLANK) ? '0 : NUM_MODES'(1) << active_mode;
    assign ch_game_start = (state == RUN && !reset && game_start) ? NUM_MODES'(1) << active_mode : '0;
    assign switch_busy = state != RUN;
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            state <= RUN;
            active_mode <= SEL_W'(DEFAULT_MODE);
            target <= SEL_W'(DEFAULT_MODE);
            blank_cnt <= '0;
            ball_x_out <= '0;
            ball_y_out <= '0;
            is_ball_moving_left <= 1'b0;
            game_over <= 1'b0;
            ball_valid <= 1'b0;
        end else begin
            ball_x_out <= (state == BLANK) ? '0 : sel_x;
            ball_y_out <= (state == BLANK) ? '0 : sel_y;
            is_ball_moving_left <= (state != BLANK) && ch_moving_left[active_mode];
            game_over <= (state != BLANK) && ch_game_over[active_mode];
            ball_valid <= state != BLANK;
            case (state)
                RUN: if (sel_q != active_mode) state <= DRAIN;
                DRAIN: begin
                    if (sel_q == active_mode) state <= RUN;
                    else if (ch_idle[active_mode] | ch_game_over[active_mode]) begin
                        target <= sel_q;
                        blank_cnt <= 8'(BLANK_CYCLES - 1);
                        state <= BLANK;
                    end
                end
                BLANK: begin
                    if (blank_cnt == 8'd0) begin
                        active_mode <= target;
                        state <= RUN;
                    end else blank_cnt <= blank_cnt - 8'd1;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_game_mode_arbiter.sv
// tb_game_mode_arbiter: directed tests of mode switching, draining, blanking and reset for game_mode_arbiter.
module tb_game_mode_arbiter;
    localparam int N = 3;
    localparam int CW = 10;
`ifdef GAME_MODE_SYNC_EN
    localparam int SL = 3;
`else
    localparam int SL = 0;
`endif
    logic clk = 1'b0, reset = 1'b1, game_start = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic [N*CW-1:0] ch_ball_x = {10'd7, 10'd100, 10'd320};
    logic [N*CW-1:0] ch_ball_y = {10'd9, 10'd50, 10'd240};
    logic [N-1:0] ch_moving_left = 3'b001, ch_game_over = 3'b000, ch_idle = 3'b000;
    logic [N-1:0] ch_enable, ch_game_start;
    logic [CW-1:0] ball_x_out, ball_y_out;
    logic is_ball_moving_left, game_over, ball_valid, switch_busy;
    logic [1:0] active_mode;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    game_mode_arbiter #(.NUM_MODES(N), .COORD_W(CW), .BLANK_CYCLES(2), .DEFAULT_MODE(0)) dut (
        .clk_25MHZ(clk), .reset(reset), .mode_sel(mode_sel), .game_start(game_start),
        .ch_ball_x(ch_ball_x), .ch_ball_y(ch_ball_y), .ch_moving_left(ch_moving_left),
        .ch_game_over(ch_game_over), .ch_idle(ch_idle), .ch_enable(ch_enable),
        .ch_game_start(ch_game_start), .ball_x_out(ball_x_out), .ball_y_out(ball_y_out),
        .is_ball_moving_left(is_ball_moving_left), .game_over(game_over), .ball_valid(ball_valid),
        .active_mode(active_mode), .switch_busy(switch_busy));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        repeat (SL) step();
    endtask

    task automatic test_reset;
        game_start = 1'b1;
        step();
        checks++; if (ball_x_out !== 10'd0) begin failures++; $display("FAIL rst_x got=%0d exp=0", ball_x_out); end
        checks++; if (ball_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ball_valid); end
        checks++; if (ch_enable !== 3'b001) begin failures++; $display("FAIL rst_enable got=%b exp=001", ch_enable); end
        checks++; if (ch_game_start !== 3'b000) begin failures++; $display("FAIL rst_gstart got=%b exp=000", ch_game_start); end
        checks++; if (switch_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", switch_busy); end
        game_start = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++; if (ball_x_out !== 10'd320 || ball_y_out !== 10'd240) begin failures++; $display("FAIL rel_xy got=%0d,%0d exp=320,240", ball_x_out, ball_y_out); end
        checks++; if (ball_valid !== 1'b1 || is_ball_moving_left !== 1'b1) begin failures++; $display("FAIL rel_valid_left got=%b%b exp=11", ball_valid, is_ball_moving_left); end
        checks++; if (ch_enable !== 3'b001 || active_mode !== 2'd0) begin failures++; $display("FAIL rel_enable got=%b/%0d exp=001/0", ch_enable, active_mode); end
    endtask

    task automatic test_start_routing;
        game_start = 1'b1;
        #1;
        checks++; if (ch_game_start !== 3'b001) begin failures++; $display("FAIL route_gstart got=%b exp=001", ch_game_start); end
        game_start = 1'b0;
        #1;
        checks++; if (ch_game_start !== 3'b000) begin failures++; $display("FAIL route_gstart_off got=%b exp=000", ch_game_start); end
    endtask

    task automatic test_busy_switch;
        mode_sel = 2'd1;
        settle();
        game_start = 1'b1;
        #1;
        checks++; if (ch_game_start !== 3'b001) begin failures++; $display("FAIL edge_gstart got=%b exp=001", ch_game_start); end
        step();
        checks++; if (switch_busy !== 1'b1 || ch_game_start !== 3'b000) begin failures++; $display("FAIL drain_enter got=%b/%b exp=1/000", switch_busy, ch_game_start); end
        game_start = 1'b0;
        ch_ball_x[CW-1:0] = 10'd321;
        step();
        step();
        checks++; if (ball_x_out !== 10'd321 || ch_enable !== 3'b001 || switch_busy !== 1'b1) begin failures++; $display("FAIL drain_hold got=%0d/%b/%b exp=321/001/1", ball_x_out, ch_enable, switch_busy); end
        ch_game_over[0] = 1'b1;
        step();
        checks++; if (ch_enable !== 3'b000 || ball_valid !== 1'b1 || game_over !== 1'b1) begin failures++; $display("FAIL blank1 got=%b/%b/%b exp=000/1/1", ch_enable, ball_valid, game_over); end
        ch_game_over[0] = 1'b0;
        step();
        checks++; if (ch_enable !== 3'b000 || ball_valid !== 1'b0 || ball_x_out !== 10'd0 || game_over !== 1'b0) begin failures++; $display("FAIL blank2 got=%b/%b/%0d/%b exp=000/0/0/0", ch_enable, ball_valid, ball_x_out, game_over); end
        step();
        checks++; if (ch_enable !== 3'b010 || active_mode !== 2'd1 || ball_valid !== 1'b0 || switch_busy !== 1'b0) begin failures++; $display("FAIL run_new got=%b/%0d/%b/%b exp=010/1/0/0", ch_enable, active_mode, ball_valid, switch_busy); end
        step();
        checks++; if (ball_x_out !== 10'd100 || ball_y_out !== 10'd50 || ball_valid !== 1'b1 || is_ball_moving_left !== 1'b0) begin failures++; $display("FAIL new_data got=%0d,%0d,%b,%b exp=100,50,1,0", ball_x_out, ball_y_out, ball_valid, is_ball_moving_left); end
    endtask

    task automatic test_cancel;
        mode_sel = 2'd0;
        settle();
        step();
        checks++; if (switch_busy !== 1'b1) begin failures++; $display("FAIL cancel_drain got=%b exp=1", switch_busy); end
        mode_sel = 2'd1;
        settle();
        step();
        checks++; if (switch_busy !== 1'b0 || active_mode !== 2'd1 || ch_enable !== 3'b010) begin failures++; $display("FAIL cancel_run got=%b/%0d/%b exp=0/1/010", switch_busy, active_mode, ch_enable); end
        step();
        checks++; if (ball_valid !== 1'b1 || ball_x_out !== 10'd100) begin failures++; $display("FAIL cancel_data got=%b/%0d exp=1/100", ball_valid, ball_x_out); end
    endtask

    task automatic test_reset_mid_blank;
        ch_idle = 3'b111;
        mode_sel = 2'd2;
        settle();
        step();
        step();
        checks++; if (ch_enable !== 3'b000 || switch_busy !== 1'b1) begin failures++; $display("FAIL mid_blank got=%b/%b exp=000/1", ch_enable, switch_busy); end
        #2 reset = 1'b1;
        mode_sel = 2'd0;
        #1;
        checks++; if (active_mode !== 2'd0 || switch_busy !== 1'b0 || ch_enable !== 3'b001) begin failures++; $display("FAIL async_rst got=%0d/%b/%b exp=0/0/001", active_mode, switch_busy, ch_enable); end
        checks++; if (ball_x_out !== 10'd0 || ball_valid !== 1'b0 || is_ball_moving_left !== 1'b0) begin failures++; $display("FAIL async_rst_out got=%0d/%b/%b exp=0/0/0", ball_x_out, ball_valid, is_ball_moving_left); end
        #1 reset = 1'b0;
        step();
        checks++; if (ball_x_out !== 10'd321 || ball_valid !== 1'b1) begin failures++; $display("FAIL post_rst got=%0d/%b exp=321/1", ball_x_out, ball_valid); end
    endtask

    task automatic test_back_to_back;
        mode_sel = 2'd2;
        settle();
        step();
        checks++; if (switch_busy !== 1'b1 || ch_enable !== 3'b001) begin failures++; $display("FAIL b2b_drain got=%b/%b exp=1/001", switch_busy, ch_enable); end
        step();
        step();
        checks++; if (ch_enable !== 3'b000 || ball_valid !== 1'b0) begin failures++; $display("FAIL b2b_blank got=%b/%b exp=000/0", ch_enable, ball_valid); end
        step();
        checks++; if (active_mode !== 2'd2 || ch_enable !== 3'b100 || switch_busy !== 1'b0) begin failures++; $display("FAIL b2b_run got=%0d/%b/%b exp=2/100/0", active_mode, ch_enable, switch_busy); end
        step();
        checks++; if (ball_x_out !== 10'd7 || ball_y_out !== 10'd9 || ball_valid !== 1'b1) begin failures++; $display("FAIL b2b_data got=%0d,%0d,%b exp=7,9,1", ball_x_out, ball_y_out, ball_valid); end
    endtask

    task automatic test_out_of_range;
        mode_sel = 2'd3;
        settle();
        repeat (3) begin
            step();
            checks++; if (switch_busy !== 1'b0 || active_mode !== 2'd2) begin failures++; $display("FAIL oor got=%b/%0d exp=0/2", switch_busy, active_mode); end
        end
        mode_sel = 2'd2;
        settle();
    endtask

`ifdef GAME_MODE_SYNC_EN
    task automatic test_glitch;
        mode_sel = 2'd1;
        step();
        mode_sel = 2'd2;
        repeat (5) begin
            step();
            checks++; if (switch_busy !== 1'b0) begin failures++; $display("FAIL glitch got=%b exp=0", switch_busy); end
        end
        mode_sel = 2'd1;
        step();
        step();
        checks++; if (switch_busy !== 1'b0) begin failures++; $display("FAIL sync_early got=%b exp=0", switch_busy); end
        step();
        step();
        checks++; if (switch_busy !== 1'b1) begin failures++; $display("FAIL sync_drain got=%b exp=1", switch_busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_start_routing();
        test_busy_switch();
        test_cancel();
        test_reset_mid_blank();
        test_back_to_back();
        test_out_of_range();
`ifdef GAME_MODE_SYNC_EN
        test_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
